// File: rtl/suu_mem_stage.sv
// suu_mem_stage: memory-access stage between ex_mem and mem_wb (req/gnt/rvalid port).
// Define SUU_MEM_ALIGN_CHECK_EN to trap misaligned half/word ops and add o_addr_err.
module suu_mem_stage #(
    parameter int AW           = 32,
    parameter int RW           = 5,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [3:0]    i_mem_op,
    input  logic [AW-1:0] i_mem_addr,
    input  logic [31:0]   i_store_data,
    input  logic [31:0]   i_w_reg_data,
    input  logic [RW-1:0] i_w_reg_addr,
    input  logic          i_wd,
    output logic          o_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          o_valid,
    output logic [31:0]   w_reg_data,
    output logic [RW-1:0] w_reg_addr,
    output logic          wd,
`ifdef SUU_MEM_ALIGN_CHECK_EN
    output logic          o_addr_err,
`endif
    output logic          o_bus_err
);

    localparam int CW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);
    localparam bit TO_EN = (WAIT_TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic to_hit;

    logic is_ld, is_st, is_mem, is_b, is_h, is_sx, misalign;
    logic go, pass, bad, st_done, ld_done, abort;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    logic          ld_q, sx_q, b_q, h_q, wd_q;
    logic [1:0]    lane_q;
    logic [31:0]   wdat_q;
    logic [RW-1:0] wa_q;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [31:0]   ld_data;

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        is_b  = 1'b0;
        is_h  = 1'b0;
        is_sx = 1'b0;
        unique case (i_mem_op)
            4'd1: begin is_ld = 1'b1; is_b = 1'b1; is_sx = 1'b1; end
            4'd2: begin is_ld = 1'b1; is_b = 1'b1; end
            4'd3: begin is_ld = 1'b1; is_h = 1'b1; is_sx = 1'b1; end
            4'd4: begin is_ld = 1'b1; is_h = 1'b1; end
            4'd5: is_ld = 1'b1;
            4'd6: begin is_st = 1'b1; is_b = 1'b1; end
            4'd7: begin is_st = 1'b1; is_h = 1'b1; end
            4'd8: is_st = 1'b1;
            default: ;
        endcase
        is_mem = is_ld | is_st;
    end

`ifdef SUU_MEM_ALIGN_CHECK_EN
    assign misalign = (is_h & i_mem_addr[0])
                    | (is_mem & ~is_b & ~is_h & (|i_mem_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = i_store_data;
        unique case (1'b1)
            is_b: begin
                be_n    = 4'b0001 << i_mem_addr[1:0];
                wdata_n = {4{i_store_data[7:0]}};
            end
            is_h: begin
                be_n    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign to_hit = TO_EN && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (go) state_n = REQ;
            REQ: begin
                if (mem_gnt)     state_n = ld_q ? RESP : IDLE;
                else if (to_hit) state_n = IDLE;
            end
            RESP: if (mem_rvalid || to_hit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        go      = 1'b0;
        pass    = 1'b0;
        bad     = 1'b0;
        st_done = 1'b0;
        ld_done = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                go      = i_valid & is_mem & ~misalign;
                pass    = i_valid & ~is_mem;
                bad     = i_valid & is_mem & misalign;
                o_stall = go;
            end
            REQ: begin
                o_stall = 1'b1;
                st_done = mem_gnt & ~ld_q;
                abort   = ~mem_gnt & to_hit;
            end
            RESP: begin
                o_stall = 1'b1;
                ld_done = mem_rvalid;
                abort   = ~mem_rvalid & to_hit;
            end
            default: ;
        endcase
    end

    // Counter restarts on every state entry, so REQ and RESP each get a full budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cnt <= '0;
        else if (state_n != state || state == IDLE) cnt <= '0;
        else                                    cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_q   <= 1'b0;
            sx_q   <= 1'b0;
            b_q    <= 1'b0;
            h_q    <= 1'b0;
            wd_q   <= 1'b0;
            lane_q <= 2'b00;
            wdat_q <= '0;
            wa_q   <= '0;
        end else if (go) begin
            ld_q   <= is_ld;
            sx_q   <= is_sx;
            b_q    <= is_b;
            h_q    <= is_h;
            wd_q   <= i_wd;
            lane_q <= is_h ? {i_mem_addr[1], 1'b0} : i_mem_addr[1:0];
            wdat_q <= i_w_reg_data;
            wa_q   <= i_w_reg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else if (go) begin
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_addr  <= {i_mem_addr[AW-1:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
        end else if (state == REQ && (mem_gnt || to_hit)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    assign ld_b = mem_rdata[{lane_q, 3'b000} +: 8];
    assign ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        unique case (1'b1)
            b_q: ld_data = {{24{sx_q & ld_b[7]}}, ld_b};
            h_q: ld_data = {{16{sx_q & ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_bus_err  <= 1'b0;
            w_reg_data <= '0;
            w_reg_addr <= '0;
            wd         <= 1'b0;
        end else begin
            o_valid   <= pass | bad | st_done | ld_done | abort;
            o_bus_err <= abort;
            wd        <= 1'b0;
            if (pass) begin
                w_reg_data <= i_w_reg_data;
                w_reg_addr <= i_w_reg_addr;
                wd         <= i_wd;
            end else if (bad) begin
                w_reg_data <= i_w_reg_data;
                w_reg_addr <= i_w_reg_addr;
            end else if (ld_done) begin
                w_reg_data <= ld_data;
                w_reg_addr <= wa_q;
                wd         <= wd_q;
            end else if (st_done || abort) begin
                w_reg_data <= wdat_q;
                w_reg_addr <= wa_q;
            end
        end
    end

`ifdef SUU_MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_addr_err <= 1'b0;
        else        o_addr_err <= bad;
    end
`endif

endmodule

// File: tb/tb_suu_mem_stage.sv
// Self-checking bench for suu_mem_stage: directed ops, a bench-side memory responder
// and a spec-level model feeding one per-cycle compare process.
module tb_suu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [3:0]  i_mem_op;
    logic [31:0] i_mem_addr, i_store_data, i_w_reg_data;
    logic [4:0]  i_w_reg_addr;
    logic        i_wd;
    logic        o_stall, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        o_valid;
    logic [31:0] w_reg_data;
    logic [4:0]  w_reg_addr;
    logic        wd, o_bus_err;
`ifdef SUU_MEM_ALIGN_CHECK_EN
    logic        o_addr_err;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wd;
        logic        bus_err;
        logic        addr_err;
        logic        chk_data;
    } wb_t;

    wb_t wbq[$];
    wb_t ce;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;

    suu_mem_stage #(.AW(32), .RW(5), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_mem_op(i_mem_op),
        .i_mem_addr(i_mem_addr), .i_store_data(i_store_data),
        .i_w_reg_data(i_w_reg_data), .i_w_reg_addr(i_w_reg_addr), .i_wd(i_wd),
        .o_stall(o_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .o_valid(o_valid), .w_reg_data(w_reg_data), .w_reg_addr(w_reg_addr),
        .wd(wd),
`ifdef SUU_MEM_ALIGN_CHECK_EN
        .o_addr_err(o_addr_err),
`endif
        .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endfunction

    function automatic int size_of(logic [3:0] op);
        if (op == 1 || op == 2 || op == 6) return 1;
        if (op == 3 || op == 4 || op == 7) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(logic [3:0] op, logic [31:0] a);
        int sz = size_of(op);
        int st = (int'(a % 4) / sz) * sz;
        return 4'(((1 << sz) - 1) << st);
    endfunction

    function automatic logic [31:0] m_wdata(logic [3:0] op, logic [31:0] d);
        int sz = size_of(op);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [3:0] op, logic [31:0] a, logic [31:0] rd);
        int sz = size_of(op);
        int st = (int'(a % 4) / sz) * sz;
        longint v;
        v = longint'(rd >> (8 * st)) & ((longint'(1) << (8 * sz)) - 1);
        if ((op == 1 || op == 3) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic bit m_misalign(logic [3:0] op, logic [31:0] a);
        int sz = size_of(op);
        return (op >= 1 && op <= 8) && sz > 1 && (a % sz) != 0;
    endfunction

    // One compare process: every output beat and every request cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (o_valid) begin
                if (wbq.size() == 0) chk("wb_unexpected", o_valid, 0);
                else begin
                    ce = wbq.pop_front();
                    if (ce.chk_data) chk("wb_data", w_reg_data, ce.data);
                    chk("wb_addr", w_reg_addr, ce.addr);
                    chk("wb_wd", wd, ce.wd);
                    chk("wb_bus_err", o_bus_err, ce.bus_err);
`ifdef SUU_MEM_ALIGN_CHECK_EN
                    chk("wb_addr_err", o_addr_err, ce.addr_err);
`endif
                end
            end else begin
                chk("bus_err_alone", o_bus_err, 0);
            end
            if (mem_req) begin
                chk("req_addr", mem_addr, exp_addr);
                chk("req_be", mem_be, exp_be);
                chk("req_wdata", mem_wdata, exp_wdata);
                chk("req_we", mem_we, exp_we);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [4:0] wa, input logic wdv,
                         input int gdly, input int rdly, input logic [31:0] rd,
                         input bit lit, input logic [31:0] la, input logic [3:0] lb,
                         input logic [31:0] lw);
        wb_t e;
        bit mem, ld, bad, abort;
        mem = (op >= 1 && op <= 8);
        ld = (op >= 1 && op <= 5);
        bad = 1'b0;
`ifdef SUU_MEM_ALIGN_CHECK_EN
        bad = m_misalign(op, a);
`endif
        abort = mem && !bad && (gdly >= TO || (ld && rdly >= TO));
        e.addr = wa;
        e.bus_err = abort;
        e.addr_err = bad;
        e.wd = !mem ? wdv : ((ld && !bad && !abort) ? wdv : 1'b0);
        e.data = !mem ? alu : m_load(op, a, rd);
        e.chk_data = !mem || (ld && !bad && !abort);
        exp_addr = {a[31:2], 2'b00};
        exp_be = m_be(op, a);
        exp_wdata = m_wdata(op, sd);
        exp_we = (op >= 6 && op <= 8);
        i_valid = 1'b1;
        i_mem_op = op;
        i_mem_addr = a;
        i_store_data = sd;
        i_w_reg_data = alu;
        i_w_reg_addr = wa;
        i_wd = wdv;
        #1 chk("stall_accept", o_stall, mem && !bad);
        wbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_mem_op = 4'd0;
        if (mem && !bad) begin
            for (int k = 0; k < 1000; k++) begin
                chk("req_hi", mem_req, 1);
                chk("stall_req", o_stall, 1);
                if (lit && k == 0) begin
                    chk("lit_addr", mem_addr, la);
                    chk("lit_be", mem_be, lb);
                    chk("lit_wdata", mem_wdata, lw);
                end
                mem_gnt = (k == gdly);
                mem_rvalid = (k == gdly);
                mem_rdata = ~rd;
                @(posedge clk);
                @(negedge clk);
                mem_gnt = 1'b0;
                mem_rvalid = 1'b0;
                if (k == gdly || k == TO - 1) break;
            end
            if (ld && gdly < TO) begin
                for (int k = 0; k < 1000; k++) begin
                    chk("req_lo_resp", mem_req, 0);
                    chk("stall_resp", o_stall, 1);
                    mem_rvalid = (k == rdly);
                    mem_rdata = (k == rdly) ? rd : 32'hDEAD_BEEF;
                    @(posedge clk);
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    if (k == rdly || k == TO - 1) break;
                end
            end
        end
        chk("done_valid", o_valid, 1);
        chk("done_req_lo", mem_req, 0);
    endtask

    task automatic abandon(input logic [3:0] op, input logic [31:0] a, input bit in_resp);
        exp_addr = {a[31:2], 2'b00};
        exp_be = m_be(op, a);
        exp_wdata = m_wdata(op, 32'h0);
        exp_we = (op >= 6);
        i_valid = 1'b1;
        i_mem_op = op;
        i_mem_addr = a;
        i_store_data = 32'h0;
        i_w_reg_addr = 5'd9;
        i_wd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_mem_op = 4'd0;
        if (in_resp) begin
            mem_gnt = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_gnt = 1'b0;
        end else begin
            chk("abn_req_pre", mem_req, 1);
        end
        chk("abn_stall_pre", o_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("abn_req", mem_req, 0);
        chk("abn_stall", o_stall, 0);
        chk("abn_valid", o_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_mem_op = 4'd0;
        i_mem_addr = '0;
        i_store_data = '0;
        i_w_reg_data = '0;
        i_w_reg_addr = '0;
        i_wd = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        exp_addr = '0;
        exp_be = '0;
        exp_wdata = '0;
        exp_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_wd", wd, 0);
        chk("rst_bus_err", o_bus_err, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata_out", w_reg_data, 0);
        chk("rst_waddr", w_reg_addr, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_mwdata", mem_wdata, 0);
        chk("rst_stall", o_stall, 0);
`ifdef SUU_MEM_ALIGN_CHECK_EN
        chk("rst_addr_err", o_addr_err, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd3, 1'b1, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("none_data", w_reg_data, 32'h1234_5678);
        chk("none_addr", w_reg_addr, 5'd3);
        chk("none_wd", wd, 1);
        issue(4'd12, 32'h55, 32'h0, 32'hAAAA_5555, 5'd7, 1'b1, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("op12_data", w_reg_data, 32'hAAAA_5555);

        issue(4'd6, 32'h103, 32'hAB, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0,
              1, 32'h100, 4'b1000, 32'hABAB_ABAB);
        chk("sb_wd", wd, 0);
        issue(4'd7, 32'h106, 32'h1234_CDEF, 32'h0, 5'd4, 1'b1, 1, 0, 32'h0,
              1, 32'h104, 4'b1100, 32'hCDEF_CDEF);
        issue(4'd8, 32'h200, 32'h0102_0304, 32'h0, 5'd4, 1'b1, 2, 0, 32'h0,
              1, 32'h200, 4'b1111, 32'h0102_0304);

        issue(4'd1, 32'h202, 32'h0, 32'h0, 5'd10, 1'b1, 3, 1, 32'h0080_0000,
              1, 32'h200, 4'b0100, 32'h0);
        chk("lb_data", w_reg_data, 32'hFFFF_FF80);
        chk("lb_addr", w_reg_addr, 5'd10);
        issue(4'd2, 32'h202, 32'h0, 32'h0, 5'd11, 1'b1, 3, 1, 32'h0080_0000, 0, 0, 0, 0);
        chk("lbu_data", w_reg_data, 32'h0000_0080);
        issue(4'd3, 32'h102, 32'h0, 32'h0, 5'd12, 1'b1, 0, 0, 32'h8001_7FFF, 0, 0, 0, 0);
        chk("lh_data", w_reg_data, 32'hFFFF_8001);
        issue(4'd4, 32'h100, 32'h0, 32'h0, 5'd13, 1'b1, 1, 2, 32'h8001_7FFF, 0, 0, 0, 0);
        chk("lhu_data", w_reg_data, 32'h0000_7FFF);
        issue(4'd5, 32'h300, 32'h0, 32'h0, 5'd14, 1'b1, 0, 0, 32'hCAFE_BABE, 0, 0, 0, 0);
        chk("lw_data", w_reg_data, 32'hCAFE_BABE);

        issue(4'd5, 32'h400, 32'h0, 32'h0, 5'd15, 1'b1, 99, 0, 32'h0, 0, 0, 0, 0);
        chk("to_bus_err", o_bus_err, 1);
        chk("to_wd", wd, 0);
        @(negedge clk);
        chk("to_pulse_err", o_bus_err, 0);
        chk("to_pulse_valid", o_valid, 0);
        issue(4'd1, 32'h401, 32'h0, 32'h0, 5'd16, 1'b1, 0, 99, 32'h0, 0, 0, 0, 0);
        chk("to_resp_err", o_bus_err, 1);

        abandon(4'd3, 32'h302, 1'b1);
        issue(4'd0, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd17, 1'b1, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("post_rst_data", w_reg_data, 32'h0BAD_F00D);
        abandon(4'd8, 32'h500, 1'b0);
        issue(4'd0, 32'h0, 32'h0, 32'h0000_0042, 5'd18, 1'b0, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("post_rst2_wd", wd, 0);

`ifdef SUU_MEM_ALIGN_CHECK_EN
        issue(4'd8, 32'h102, 32'h1111_2222, 32'h0, 5'd19, 1'b1, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("align_err", o_addr_err, 1);
        chk("align_wd", wd, 0);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("wbq_drained", wbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/suu_mem_stage.md
# suu_mem_stage

Parametrised memory-access pipeline stage sitting between `ex_mem` and `mem_wb` in the suu_cpu pipeline. Non-memory instructions pass through in one registered cycle. Loads and stores are issued on a req/gnt/rvalid data-memory port, with byte enables, load extraction and sign/zero extension, and a bus timeout. The stage stalls upstream while a memory access is in flight.

## Interface
- `AW`, 32: data-memory address width.
- `RW`, 5: register-file address width.
- `WAIT_TIMEOUT`, 16: maximum cycles spent in REQ or RESP before abort; 0 disables the timeout.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_valid`  in  1  input instruction valid.
- `i_mem_op`  in  4  operation: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Codes 9–15 are treated as NONE.
- `i_mem_addr`  in  AW  effective byte address.
- `i_store_data`  in  32  store data, right-aligned.
- `i_w_reg_data`  in  32  ALU result, used by non-load ops.
- `i_w_reg_addr`  in  RW  destination register.
- `i_wd`  in  1  register write enable.
- `o_stall`  out  1  upstream must hold its inputs.
- `mem_req`, `mem_we`  out  1  request, write.
- `mem_addr`  out  AW  word address; bits [1:0] are always 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`, `mem_rvalid`  in  1  grant, read data valid.
- `mem_rdata`  in  32  read data.
- `o_valid`  out  1  output valid to `mem_wb`.
- `w_reg_data`  out  32  write-back data.
- `w_reg_addr`  out  RW  write-back register.
- `wd`  out  1  write-back enable.
- `o_bus_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, REQ, RESP.
- IDLE, `i_valid`, NONE op:
  - Register `w_reg_data`/`w_reg_addr`/`wd` from the inputs.
  - Set `o_valid`=1.
  - Stay in IDLE.
- IDLE, `i_valid`, memory op:
  - Capture all inputs.
  - Go to REQ.
- REQ:
  - `mem_req`=1, holding `mem_addr`/`mem_we`/`mem_be`/`mem_wdata` stable until `mem_gnt` is sampled 1.
  - On grant, a store goes to IDLE and outputs `o_valid`=1, `wd`=0.
  - On grant, a load goes to RESP.
- RESP:
  - `mem_rvalid` is ignored in the grant cycle; it is accepted only in RESP.
  - On `mem_rvalid`, extract data and output `o_valid`=1 with captured `w_reg_addr` and `wd`; go to IDLE.
- Byte enables and store data:
  - Byte ops: `mem_be` = 1<<addr[1:0].
  - Half ops: `mem_be` = 4'b0011 << (addr[1]*2).
  - Word ops: `mem_be` = 4'b1111.
  - Store data is replicated: byte ×4, half ×2.
- Load extraction:
  - Byte lane addr[1:0], half lane addr[1].
  - LB/LH sign-extend to 32; LBU/LHU zero-extend.
- Timeout:
  - A counter clears on entry to REQ and to RESP.
  - At count WAIT_TIMEOUT-1 without the awaited event: drop `mem_req`, go to IDLE, output `o_valid`=1, `wd`=0, and pulse `o_bus_err`.
- `o_stall` = (state≠IDLE) | (state==IDLE & `i_valid` & memory op).
- Reset mid-access: state returns to IDLE and `mem_req` drops immediately; the in-flight access is abandoned.

## Timing
- Reset values:
  - `o_valid`, `wd`, `o_bus_err`, `mem_req`, `mem_we` = 0.
  - `w_reg_data` = 0, `w_reg_addr` = 0, `mem_addr` = 0, `mem_be` = 0, `mem_wdata` = 0.
  - State = IDLE, counter = 0.
- `o_valid`, `w_reg_*`, `wd` and `o_bus_err` are registered. `o_valid` and `o_bus_err` last exactly 1 cycle per instruction.
- NONE op: latency 1 cycle, no stall.
- Store accepted at t with grant at first REQ cycle: `mem_req` at t+1, `o_valid` at t+2. Stall is asserted at t and t+1.
- Load: `o_valid` is asserted the cycle after the `mem_rvalid` cycle.
- Back-to-back: a new instruction may be accepted in the same cycle `o_valid` is driven for the previous one (state is IDLE).

## Configuration
- `SUU_MEM_ALIGN_CHECK_EN` defined:
  - A halfword op with addr[0]=1, or a word op with addr[1:0]≠0, issues no request.
  - The stage outputs `o_valid`=1, `wd`=0 next cycle.
  - Adds output `o_addr_err` (1 bit, registered, reset 0), which pulses 1 cycle.
- Undefined: no alignment check and no `o_addr_err` port. Low address bits select lanes as given under Operation, with the lower bits that a half/word op ignores simply discarded.

## Test plan
- NONE op, `i_w_reg_data`=32'h1234_5678, addr 5'd3, wd=1 -> next cycle `o_valid`=1, `w_reg_data`=32'h1234_5678, `w_reg_addr`=3, `o_stall` never 1.
- SB, addr 32'h103, data 32'hAB, grant first cycle -> `mem_addr`=32'h100, `mem_be`=4'b1000, `mem_wdata`=32'hABAB_ABAB, `o_valid` 2 cycles after accept with `wd`=0.
- LB, addr 32'h202, `mem_rdata`=32'h0080_0000, grant delayed 3 cycles, rvalid 2 cycles later -> `w_reg_data`=32'hFFFF_FF80; LBU on the same access -> 32'h0000_0080.
- LW, WAIT_TIMEOUT=4, `mem_gnt` held 0 -> `mem_req` drops after 4 REQ cycles, `o_bus_err`=1 for 1 cycle, `wd`=0.
- LH in RESP, `rst_n` pulsed low -> `mem_req`=0 and `o_stall`=0 immediately; the next NONE op completes normally.
- With `SUU_MEM_ALIGN_CHECK_EN`: SW at 32'h102 -> no `mem_req`, `o_addr_err`=1 and `o_valid`=1 next cycle.
